multiword_alu: RTL and testbench
================================

// Module: multiword_alu
// PURPOSE
//  Sequential multi-word ALU. Operands are WORDS*WIDTH bits wide and are processed one WIDTH-bit slice per cycle.
//  Carry, borrow and shift bits chain between slices, so the datapath can run wide arithmetic with one narrow slice.
//  Sits beside the datapath register file; the controller drives start/op and waits for done.
//  Adds, over the single-cycle ALU: width/depth parameters, a start/busy/done handshake, a correct SUB borrow
//  and registered flags.
// PARAMETERS
//  WIDTH   8   bits per slice (the width of the slice datapath)
//  WORDS   2   slices per operand; total operand width = WORDS*WIDTH; must be >= 1
// PORTS
//  Clk       in   1              clock, rising edge
//  Reset     in   1              synchronous, active-high reset
//  start     in   1              request; sampled only in IDLE
//  op        in   3              op_t opcode, latched with start
//  a_in      in   WORDS*WIDTH    operand A, latched with start
//  b_in      in   WORDS*WIDTH    operand B, latched with start
//  sc_in     in   1              shift-in / carry-in, latched with start
//  busy      out  1              high in RUN and DONE
//  done      out  1              one-cycle pulse; result and flags valid from this cycle
//  result    out  WORDS*WIDTH    registered result, held until the next accepted start
//  sc_out    out  1              final carry / shift-out bit
//  zero      out  1              result == 0
//  beven     out  1              ~result[0]
//  parity    out  1              ^a (reduction XOR of latched A)
//  equal     out  1              latched A == latched B
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, result, sc_out, parity and equal are all 0; zero=1 and beven=1.
//   Reset wins over any other event, including mid-RUN. A reset during RUN discards the operation: no done pulse.
//  FSM: IDLE --start--> RUN (cnt=0) --after WORDS slice cycles--> DONE --> IDLE.
//   start is ignored in RUN and DONE; it is not queued.
//  Latency: start sampled at edge 0; done is high during the cycle after edge WORDS+1.
//   Back-to-back throughput is one op per WORDS+2 cycles.
//  Slice order: LSW first for ADD, SUB, LSH, XOR, AND; MSW first for RSH.
//   The chain bit c is registered between slices.
//  Initial chain bit c0 and final sc_out, per opcode:
//   kADD=3'd0  slice = a+b+c, 9-bit result split {c,out}; c0=sc_in; sc_out=final carry
//   kLSH=3'd1  slice = {a[W-2:0],c}, next c=a[W-1]; c0=sc_in; sc_out=MSB of A
//   kRSH=3'd2  slice = {c,a[W-1:1]}, next c=a[0]; c0=sc_in; sc_out=LSB of A
//   kXOR=3'd3  a^b; sc_out=0
//   kAND=3'd4  a&b; sc_out=0
//   kSUB=3'd5  a+~b+c, chained; c0=1 (sc_in ignored); sc_out=1 means no borrow (A>=B unsigned)
//   3'd6,3'd7  no-op: result=0, sc_out=0, so zero=1
//  All arithmetic is unsigned modulo 2^(WORDS*WIDTH); overflow is visible only through sc_out.
//  Flags: zero, beven and sc_out update on the edge that enters DONE. parity and equal update at start accept.
//   All flags hold until the next accepted start or Reset.
//  result is built in place, slice by slice. The intermediate value is visible while busy=1 and is not valid
//   until done.
//  WORDS=1: one RUN cycle; behaviour is otherwise identical.
// STRUCTURE
//  definitions package: op_t enum (kADD..kSUB, kNOP6, kNOP7) and state_t {IDLE, RUN, DONE}.
//  Sub-module alu_slice (combinational, WIDTH param): inputs a, b, c, op; outputs out, c_next.
//  multiword_alu holds the FSM, slice counter $clog2(WORDS+1) bits, operand/result registers, chain bit and flags.
// TESTING (WIDTH=8, WORDS=2 unless noted)
//  ADD A=16'h00FF B=16'h0001 sc_in=0 -> result 16'h0100, sc_out 0, zero 0, done exactly 3 cycles after start
//  SUB A=B=16'h1234 -> result 16'h0000, sc_out 1, zero 1, equal 1; SUB 16'h0001-16'h0002 -> 16'hFFFF, sc_out 0
//  LSH A=16'hB3B3 sc_in=1 -> result 16'h6767, sc_out 1, beven 0; RSH A=16'h0001 sc_in=1 -> 16'h8000, sc_out 1
//  Reset in the first RUN cycle -> next cycle busy=0, result=0, and no done pulse ever follows
//  start held high through RUN with a different op -> ignored; exactly one done; result matches the first op
//  WORDS=4: ADD 32'hFFFFFFFF+1 -> result 0, sc_out 1, zero 1, done 5 cycles after start; parity of A = 0

Source files
------------

// File: rtl/multiword_alu_pkg.sv
// multiword_alu_pkg: opcode and FSM state types shared by the multi-word ALU and its slice
package multiword_alu_pkg;
  typedef enum logic [2:0] {kADD, kLSH, kRSH, kXOR, kAND, kSUB, kNOP6, kNOP7} op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational one-slice ALU with chained carry/borrow/shift bit
module alu_slice
  import multiword_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  op_t              op,
  output logic [WIDTH-1:0] out,
  output logic             c_next
);
  logic [WIDTH:0] sum;
  // SUB is a + ~b + c with the chain seeded to 1, so carry-out 1 means no borrow
  assign sum = {1'b0, a} + {1'b0, op == kSUB ? ~b : b} + {{WIDTH{1'b0}}, c};
  always_comb begin
    out = (op == kADD || op == kSUB) ? sum[WIDTH-1:0] :
          op == kLSH ? {a[WIDTH-2:0], c} :
          op == kRSH ? {c, a[WIDTH-1:1]} :
          op == kXOR ? a ^ b :
          op == kAND ? a & b : '0;
    c_next = (op == kADD || op == kSUB) ? sum[WIDTH] :
             op == kLSH ? a[WIDTH-1] :
             op == kRSH ? a[0] : 1'b0;
  end
endmodule

// File: rtl/multiword_alu.sv
// multiword_alu: sequential WORDS*WIDTH-bit ALU processing one WIDTH-bit slice per cycle
module multiword_alu
  import multiword_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [WORDS*WIDTH-1:0] a_in,
  input  logic [WORDS*WIDTH-1:0] b_in,
  input  logic                   sc_in,
  output logic                   busy,
  output logic                   done,
  output logic [WORDS*WIDTH-1:0] result,
  output logic                   sc_out,
  output logic                   zero,
  output logic                   beven,
  output logic                   parity,
  output logic                   equal
);
  localparam int N  = WORDS * WIDTH;
  localparam int CW = $clog2(WORDS + 1);
  state_t         state, state_n;
  op_t            op_r;
  logic [N-1:0]   a_r, b_r, next_result;
  logic [CW-1:0]  cnt, idx;
  logic [WIDTH-1:0] s_out;
  logic           c, c_next, last;
  assign last = cnt == CW'(WORDS - 1);
  // RSH walks MSW first so the chain bit flows downward
  assign idx  = op_r == kRSH ? CW'(WORDS - 1) - cnt : cnt;
  assign busy = state != IDLE;
  alu_slice #(.WIDTH(WIDTH)) u_slice (
    .a      (a_r[idx*WIDTH +: WIDTH]),
    .b      (b_r[idx*WIDTH +: WIDTH]),
    .c      (c),
    .op     (op_r),
    .out    (s_out),
    .c_next (c_next)
  );
  always_comb begin
    next_result = result;
    next_result[idx*WIDTH +: WIDTH] = s_out;
  end
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_r   <= kADD;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      sc_out <= 1'b0;
      zero   <= 1'b1;
      beven  <= 1'b1;
      parity <= 1'b0;
      equal  <= 1'b0;
    end else begin
      done <= state == DONE;
      if (state == IDLE && start) begin
        op_r   <= op_t'(op);
        a_r    <= a_in;
        b_r    <= b_in;
        cnt    <= '0;
        c      <= op_t'(op) == kSUB ? 1'b1 : sc_in;
        parity <= ^a_in;
        equal  <= a_in == b_in;
      end else if (state == RUN) begin
        result <= next_result;
        c      <= c_next;
        cnt    <= cnt + 1'b1;
        if (last) begin
          sc_out <= c_next;
          zero   <= next_result == '0;
          beven  <= ~next_result[0];
        end
      end
    end
  end
endmodule

// File: tb/tb_multiword_alu.sv
// tb_multiword_alu: directed-vector bench for the 2-word and 4-word multi-word ALU
module tb_multiword_alu;
  logic clk = 1'b0, rst = 1'b1;
  logic start2 = 1'b0, start4 = 1'b0, sc_in = 1'b0;
  logic [2:0] op = 3'd0;
  logic [15:0] a2 = '0, b2 = '0, r2;
  logic [31:0] a4 = '0, b4 = '0, r4;
  logic busy2, done2, sc2, zero2, beven2, par2, eq2;
  logic busy4, done4, sc4, zero4, beven4, par4, eq4;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  multiword_alu #(.WIDTH(8), .WORDS(2)) u_dut2 (
    .Clk(clk), .Reset(rst), .start(start2), .op(op), .a_in(a2), .b_in(b2), .sc_in(sc_in),
    .busy(busy2), .done(done2), .result(r2), .sc_out(sc2), .zero(zero2), .beven(beven2),
    .parity(par2), .equal(eq2)
  );
  multiword_alu #(.WIDTH(8), .WORDS(4)) u_dut4 (
    .Clk(clk), .Reset(rst), .start(start4), .op(op), .a_in(a4), .b_in(b4), .sc_in(sc_in),
    .busy(busy4), .done(done4), .result(r4), .sc_out(sc4), .zero(zero4), .beven(beven4),
    .parity(par4), .equal(eq4)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic go(input logic w4, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic s, input int lat);
    int n;
    @(negedge clk);
    op = o;
    sc_in = s;
    if (w4) begin a4 = a; b4 = b; start4 = 1'b1; end
    else begin a2 = a[15:0]; b2 = b[15:0]; start2 = 1'b1; end
    @(posedge clk);
    #1 start2 = 1'b0;
    start4 = 1'b0;
    n = 0;
    while (!(w4 ? done4 : done2) && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 64'(n), 64'(lat));
  endtask
  initial begin
    int dones;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy2), 64'd0);
    chk("rst_done", 64'(done2), 64'd0);
    chk("rst_result", 64'(r2), 64'd0);
    chk("rst_sc", 64'(sc2), 64'd0);
    chk("rst_zero", 64'(zero2), 64'd1);
    chk("rst_beven", 64'(beven2), 64'd1);
    chk("rst_parity", 64'(par2), 64'd0);
    chk("rst_equal", 64'(eq2), 64'd0);
    rst = 1'b0;
    go(1'b0, 3'd0, 32'h00FF, 32'h0001, 1'b0, 3);
    chk("add_res", 64'(r2), 64'h0100);
    chk("add_sc", 64'(sc2), 64'd0);
    chk("add_zero", 64'(zero2), 64'd0);
    chk("add_parity", 64'(par2), 64'd0);
    chk("add_busy", 64'(busy2), 64'd0);
    go(1'b0, 3'd0, 32'hFFFF, 32'h0000, 1'b1, 3);
    chk("addc_res", 64'(r2), 64'h0000);
    chk("addc_sc", 64'(sc2), 64'd1);
    go(1'b0, 3'd5, 32'h1234, 32'h1234, 1'b0, 3);
    chk("sub_eq_res", 64'(r2), 64'h0000);
    chk("sub_eq_sc", 64'(sc2), 64'd1);
    chk("sub_eq_zero", 64'(zero2), 64'd1);
    chk("sub_eq_equal", 64'(eq2), 64'd1);
    chk("sub_eq_parity", 64'(par2), 64'd1);
    go(1'b0, 3'd5, 32'h0001, 32'h0002, 1'b1, 3);
    chk("sub_bor_res", 64'(r2), 64'hFFFF);
    chk("sub_bor_sc", 64'(sc2), 64'd0);
    chk("sub_bor_equal", 64'(eq2), 64'd0);
    go(1'b0, 3'd1, 32'hB3B3, 32'h0000, 1'b1, 3);
    chk("lsh_res", 64'(r2), 64'h6767);
    chk("lsh_sc", 64'(sc2), 64'd1);
    chk("lsh_beven", 64'(beven2), 64'd0);
    go(1'b0, 3'd2, 32'h0001, 32'h0000, 1'b1, 3);
    chk("rsh_res", 64'(r2), 64'h8000);
    chk("rsh_sc", 64'(sc2), 64'd1);
    go(1'b0, 3'd3, 32'hF0F0, 32'hFF00, 1'b1, 3);
    chk("xor_res", 64'(r2), 64'h0FF0);
    chk("xor_sc", 64'(sc2), 64'd0);
    go(1'b0, 3'd4, 32'hF0F0, 32'hFF00, 1'b0, 3);
    chk("and_res", 64'(r2), 64'hF000);
    go(1'b0, 3'd6, 32'hABCD, 32'h1234, 1'b1, 3);
    chk("nop_res", 64'(r2), 64'h0000);
    chk("nop_zero", 64'(zero2), 64'd1);
    chk("nop_sc", 64'(sc2), 64'd0);
    go(1'b0, 3'd0, 32'h1111, 32'h2222, 1'b0, 3);
    chk("pre_rst_res", 64'(r2), 64'h3333);
    @(negedge clk);
    op = 3'd0; a2 = 16'h0101; b2 = 16'h0101; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    chk("run_busy", 64'(busy2), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_busy", 64'(busy2), 64'd0);
    chk("midrst_res", 64'(r2), 64'd0);
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1 dones += int'(done2);
    end
    chk("midrst_nodone", 64'(dones), 64'd0);
    @(negedge clk);
    op = 3'd0; a2 = 16'h0003; b2 = 16'h0004; sc_in = 1'b0; start2 = 1'b1;
    @(posedge clk);
    #1 op = 3'd3;
    a2 = 16'hFFFF;
    dones = 0;
    for (int i = 0; i < 20 && dones == 0; i++) begin
      @(posedge clk);
      #1 dones += int'(done2);
    end
    start2 = 1'b0;
    chk("hold_res", 64'(r2), 64'h0007);
    repeat (8) begin
      @(posedge clk);
      #1 dones += int'(done2);
    end
    chk("hold_dones", 64'(dones), 64'd1);
    go(1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 5);
    chk("w4_res", 64'(r4), 64'h0);
    chk("w4_sc", 64'(sc4), 64'd1);
    chk("w4_zero", 64'(zero4), 64'd1);
    chk("w4_parity", 64'(par4), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
